axi_lite_slave_regs: RTL

AXI4-Lite responder (slave) with a small bank of 32-bit control/status registers. It is the target end of the AXI interface driven by the existing initiator. It accepts write address/data, returns write responses, serves reads, and exposes register 0 as a parallel output to downstream logic.

---
 rtl/axi_lite_slave_regs.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder with a small bank of byte-writable 32-bit registers; register 0 drives REG0_OUT.
// Define AXI_SLV_ID_REG_EN to map a read-only ID register at index NUM_REGS.
module axi_lite_slave_regs #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 4,
  parameter logic [31:0] ID_VALUE   = 32'hA11E0001
) (
  input  logic                    ACLK,
  input  logic                    ARST,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_WIDTH-1:0]   REG0_OUT
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] NREGS       = NUM_REGS;
  localparam int          NBYTES      = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NBYTES-1:0]     strb_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]     wr_strb;
  logic [31:0]           wr_idx, rd_idx;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_ADDR;
        else if (w_hs)     w_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)   w_next = W_RESP;
      W_HAVE_DATA: if (aw_hs)  w_next = W_RESP;
      W_RESP:      if (BREADY) w_next = W_IDLE;
      default:     w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_hs) addr_q <= AWADDR;
      if (w_hs) begin
        data_q <= WDATA;
        strb_q <= WSTRB;
      end
    end
  end

  // The half that arrived first was latched; the other half is taken live from the bus.
  always_comb begin
    commit  = (w_next == W_RESP) && (w_state != W_RESP);
    wr_addr = (w_state == W_HAVE_ADDR) ? addr_q : AWADDR;
    wr_data = (w_state == W_HAVE_DATA) ? data_q : WDATA;
    wr_strb = (w_state == W_HAVE_DATA) ? strb_q : WSTRB;
    wr_idx  = 32'(wr_addr[ADDR_WIDTH-1:2]);
    wr_ok   = wr_idx < NREGS;
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == 32'(i)) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Ready/valid flops are loaded from the next state so every output comes straight from a register.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
    end else begin
      AWREADY <= (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
      WREADY  <= (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
      BVALID  <= (w_next == W_RESP);
      if (commit) BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign REG0_OUT = regs[0];

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)  r_next = R_DATA;
      R_DATA:  if (RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_idx  = 32'(ARADDR[ADDR_WIDTH-1:2]);
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 32'(i)) begin
        rd_data = regs[i];
        rd_resp = RESP_OKAY;
      end
    end
`ifdef AXI_SLV_ID_REG_EN
    if (rd_idx == NREGS) begin
      rd_data = ID_VALUE;
      rd_resp = RESP_OKAY;
    end
`endif
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_DATA);
      if (ar_hs) begin
        RDATA <= rd_data;
        RRESP <= rd_resp;
      end
    end
  end

  // Byte-offset bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[1:0], ARADDR[1:0]};

`ifndef AXI_SLV_ID_REG_EN
  logic [31:0] unused_id_value;
  assign unused_id_value = ID_VALUE;
`endif

endmodule
